// File: rtl/reg_status_table_param_if.sv
// Dispatch, CDB, read-port and finished-handshake signals of the register status table.
// The master modport drives requests; the slave modport is the table itself.
interface reg_status_table_param_if #(
    parameter int NUM_REGS = 4,
    parameter int DATA_W   = 16,
    parameter int NUM_RS   = 2,
    parameter int TAG_W    = 3,
    parameter int REG_AW   = 2
);
    logic              disp_valid;
    logic [REG_AW-1:0] disp_rd;
    logic [TAG_W-1:0]  disp_tag;
    logic              cdb_valid;
    logic [TAG_W-1:0]  cdb_tag;
    logic [DATA_W-1:0] cdb_data;
    logic              flush;
    logic [REG_AW-1:0] rd_addr_a;
    logic [REG_AW-1:0] rd_addr_b;
    logic [TAG_W-1:0]  rd_qi_a;
    logic [TAG_W-1:0]  rd_qi_b;
    logic [DATA_W-1:0] rd_val_a;
    logic [DATA_W-1:0] rd_val_b;
    logic [NUM_RS-1:0] fin_ack;
    logic [NUM_RS-1:0] finished;
    logic [REG_AW:0]   busy_count;
    logic              tag_err;

    modport master (
        output disp_valid, disp_rd, disp_tag, cdb_valid, cdb_tag, cdb_data, flush,
               rd_addr_a, rd_addr_b, fin_ack,
        input  rd_qi_a, rd_qi_b, rd_val_a, rd_val_b, finished, busy_count, tag_err
    );

    modport slave (
        input  disp_valid, disp_rd, disp_tag, cdb_valid, cdb_tag, cdb_data, flush,
               rd_addr_a, rd_addr_b, fin_ack,
        output rd_qi_a, rd_qi_b, rd_val_a, rd_val_b, finished, busy_count, tag_err
    );
endinterface

// File: rtl/reg_status_table_param.sv
// Tomasulo register status table: producer tags, committed values, CDB snoop with read bypass.
// Optional feature macro RST_FLUSH_EN: when defined, 'flush' clears all producer tags.
module reg_status_table_param #(
    parameter int NUM_REGS = 4,
    parameter int DATA_W   = 16,
    parameter int NUM_RS   = 2,
    parameter int TAG_W    = 3,
    parameter int REG_AW   = 2
) (
    input logic                     Clock,
    input logic                     Reset,
    reg_status_table_param_if.slave bus
);
    localparam int CNT_W = REG_AW + 1;

    logic [TAG_W-1:0]  r_qi  [NUM_REGS];
    logic [DATA_W-1:0] r_val [NUM_REGS];
    logic [NUM_RS-1:0] r_finished;
    logic [CNT_W-1:0]  r_busy_count;
    logic              r_tag_err;

    logic [TAG_W-1:0]  w_qi_nxt  [NUM_REGS];
    logic [DATA_W-1:0] w_val_nxt [NUM_REGS];
    logic [NUM_RS-1:0] w_fin_nxt;
    logic [CNT_W-1:0]  w_busy_nxt;
    logic              w_disp_ok;
    logic              w_cdb_ok;
    logic              w_err;

    // Legal tags are 1..NUM_RS; tag 0 means "no producer".
    assign w_disp_ok = bus.disp_valid && (bus.disp_tag != '0) && (bus.disp_tag <= TAG_W'(NUM_RS));
    assign w_cdb_ok  = bus.cdb_valid  && (bus.cdb_tag  != '0) && (bus.cdb_tag  <= TAG_W'(NUM_RS));
    assign w_err     = (bus.disp_valid && !w_disp_ok) || (bus.cdb_valid && !w_cdb_ok);

    // NOTE: combinational blocks assign every output a default first so no latch is inferred.
    always_comb begin
        w_qi_nxt   = r_qi;
        w_val_nxt  = r_val;
        w_busy_nxt = '0;
        w_fin_nxt  = r_finished & ~bus.fin_ack;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (w_cdb_ok && (r_qi[k] == bus.cdb_tag)) begin
                w_val_nxt[k] = bus.cdb_data;
                w_qi_nxt[k]  = '0;
            end
        end
        // Dispatch is the newer producer, so it overrides a same-edge CDB clear.
        if (w_disp_ok) begin
            w_qi_nxt[bus.disp_rd] = bus.disp_tag;
        end
`ifdef RST_FLUSH_EN
        if (bus.flush) begin
            for (int k = 0; k < NUM_REGS; k++) begin
                w_qi_nxt[k] = '0;
            end
        end
`endif
        for (int k = 0; k < NUM_REGS; k++) begin
            if (w_qi_nxt[k] != '0) begin
                w_busy_nxt = w_busy_nxt + CNT_W'(1);
            end
        end
        for (int i = 0; i < NUM_RS; i++) begin
            if (w_cdb_ok && (bus.cdb_tag == TAG_W'(i + 1))) begin
                w_fin_nxt[i] = 1'b1;
            end
        end
    end

    // NOTE: the register file is reset too, because each register must come up holding its own index.
    always_ff @(negedge Clock or posedge Reset) begin
        if (Reset) begin
            for (int k = 0; k < NUM_REGS; k++) begin
                r_qi[k]  <= '0;
                r_val[k] <= DATA_W'(k);
            end
            r_finished   <= '0;
            r_busy_count <= '0;
            r_tag_err    <= 1'b0;
        end else begin
            // NOTE: state is updated with non-blocking assignments so every register sees pre-edge values.
            r_qi         <= w_qi_nxt;
            r_val        <= w_val_nxt;
            r_finished   <= w_fin_nxt;
            r_busy_count <= w_busy_nxt;
            r_tag_err    <= r_tag_err | w_err;
        end
    end

    // Read ports show pre-edge state, forwarding a matching broadcast in the same cycle.
    always_comb begin
        bus.rd_qi_a  = r_qi[bus.rd_addr_a];
        bus.rd_val_a = r_val[bus.rd_addr_a];
        bus.rd_qi_b  = r_qi[bus.rd_addr_b];
        bus.rd_val_b = r_val[bus.rd_addr_b];
        if (w_cdb_ok && (r_qi[bus.rd_addr_a] == bus.cdb_tag)) begin
            bus.rd_qi_a  = '0;
            bus.rd_val_a = bus.cdb_data;
        end
        if (w_cdb_ok && (r_qi[bus.rd_addr_b] == bus.cdb_tag)) begin
            bus.rd_qi_b  = '0;
            bus.rd_val_b = bus.cdb_data;
        end
    end

    assign bus.finished   = r_finished;
    assign bus.busy_count = r_busy_count;
    assign bus.tag_err    = r_tag_err;
endmodule

// File: tb/tb_reg_status_table_param.sv
// Randomized self-checking bench for reg_status_table_param against an array-based model.
// Directed cases cover bypass, collisions, illegal tags, the finished handshake and async reset.
module tb_reg_status_table_param;
    localparam int NUM_REGS = 4;
    localparam int DATA_W   = 16;
    localparam int NUM_RS   = 2;
    localparam int TAG_W    = 3;
    localparam int REG_AW   = 2;

    logic Clock;
    logic Reset;
    int   total_cnt;
    int   bad_cnt;

    // Reference model state
    int   m_qi  [NUM_REGS];
    int   m_val [NUM_REGS];
    int   m_fin;
    int   m_err;

    reg_status_table_param_if #(
        .NUM_REGS(NUM_REGS), .DATA_W(DATA_W), .NUM_RS(NUM_RS), .TAG_W(TAG_W), .REG_AW(REG_AW)
    ) bus ();

    reg_status_table_param #(
        .NUM_REGS(NUM_REGS), .DATA_W(DATA_W), .NUM_RS(NUM_RS), .TAG_W(TAG_W), .REG_AW(REG_AW)
    ) dut (
        .Clock(Clock),
        .Reset(Reset),
        .bus  (bus.slave)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got=%0h expected=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit legal(input int t);
        return (t >= 1) && (t <= NUM_RS);
    endfunction

    function automatic int model_busy();
        int n = 0;
        foreach (m_qi[k]) if (m_qi[k] != 0) n++;
        return n;
    endfunction

    function automatic void model_reset();
        foreach (m_qi[k]) begin
            m_qi[k]  = 0;
            m_val[k] = k;
        end
        m_fin = 0;
        m_err = 0;
    endfunction

    task automatic check_read(input string tag, input int addr, input logic [TAG_W-1:0] qi,
                              input logic [DATA_W-1:0] val, input int cv, input int ctag, input int cdata);
        int eq = m_qi[addr];
        int ev = m_val[addr];
        if (cv != 0 && legal(ctag) && m_qi[addr] == ctag) begin
            eq = 0;
            ev = cdata;
        end
        check({tag, "_qi"}, 32'(qi), 32'(eq));
        check({tag, "_val"}, 32'(val), 32'(ev));
    endtask

    // One clock cycle: drive at posedge, check reads mid-cycle, apply the negedge, check state.
    task automatic step(input int dv, input int drd, input int dtag, input int cv, input int ctag,
                        input int cdata, input int fl, input int ack, input int ra, input int rb);
        int old_qi [NUM_REGS];
        @(posedge Clock);
        bus.disp_valid = dv[0];
        bus.disp_rd    = REG_AW'(drd);
        bus.disp_tag   = TAG_W'(dtag);
        bus.cdb_valid  = cv[0];
        bus.cdb_tag    = TAG_W'(ctag);
        bus.cdb_data   = DATA_W'(cdata);
        bus.flush      = fl[0];
        bus.fin_ack    = NUM_RS'(ack);
        bus.rd_addr_a  = REG_AW'(ra);
        bus.rd_addr_b  = REG_AW'(rb);
        #1;
        check_read("rd_a", ra, bus.rd_qi_a, bus.rd_val_a, cv, ctag, cdata);
        check_read("rd_b", rb, bus.rd_qi_b, bus.rd_val_b, cv, ctag, cdata);
        @(negedge Clock);
        old_qi = m_qi;
        m_fin = m_fin & ~ack;
        if (cv != 0) begin
            if (legal(ctag)) begin
                foreach (m_qi[k]) if (old_qi[k] == ctag) begin
                    m_qi[k]  = 0;
                    m_val[k] = cdata;
                end
                m_fin = m_fin | (1 << (ctag - 1));
            end else m_err = 1;
        end
        if (dv != 0) begin
            if (legal(dtag)) m_qi[drd] = dtag;
            else m_err = 1;
        end
`ifdef RST_FLUSH_EN
        if (fl != 0) foreach (m_qi[k]) m_qi[k] = 0;
`endif
        #1;
        check("busy_count", 32'(bus.busy_count), 32'(model_busy()));
        check("finished", 32'(bus.finished), 32'(m_fin));
        check("tag_err", 32'(bus.tag_err), 32'(m_err));
    endtask

    task automatic idle(input int ra, input int rb);
        step(0, 0, 0, 0, 0, 0, 0, 0, ra, rb);
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        model_reset();
        repeat (2) @(negedge Clock);
        @(posedge Clock);
        Reset = 1'b0;
    endtask

    initial begin
        total_cnt = 0;
        bad_cnt   = 0;
        bus.disp_valid = 1'b0; bus.disp_rd = '0; bus.disp_tag = '0;
        bus.cdb_valid = 1'b0; bus.cdb_tag = '0; bus.cdb_data = '0;
        bus.flush = 1'b0; bus.fin_ack = '0; bus.rd_addr_a = '0; bus.rd_addr_b = '0;
        do_reset();

        // Reset state: each register holds its index
        idle(0, 1);
        idle(2, 3);

        // Two registers waiting on the same tag, cleared by one broadcast
        step(1, 2, 1, 0, 0, 0, 0, 0, 2, 3);
        step(1, 3, 1, 0, 0, 0, 0, 0, 2, 3);
        check("t2_busy_before", 32'(bus.busy_count), 32'd2);
        step(0, 0, 0, 1, 1, 16'h00AA, 0, 0, 2, 3);
        check("t2_busy_after", 32'(bus.busy_count), 32'd0);
        check("t2_finished", 32'(bus.finished), 32'd1);
        idle(2, 3);
        check("t2_r3_val", 32'(bus.rd_val_b), 32'h00AA);
        step(0, 0, 0, 0, 0, 0, 0, 1, 0, 1);

        // Bypass on read port a
        step(1, 1, 2, 0, 0, 0, 0, 0, 1, 1);
        step(0, 0, 0, 1, 2, 16'h1234, 0, 0, 1, 0);
        idle(1, 1);
        check("t3_r1_val", 32'(bus.rd_val_a), 32'h1234);

        // Same-edge collision: value from CDB, tag from dispatch
        step(1, 0, 1, 0, 0, 0, 0, 3, 0, 0);
        step(1, 0, 2, 1, 1, 16'h0055, 0, 0, 0, 0);
        idle(0, 0);
        check("t4_r0_qi", 32'(bus.rd_qi_a), 32'd2);
        check("t4_r0_val", 32'(bus.rd_val_a), 32'h0055);

        // Illegal tags, sticky error, finished set beats ack
        step(1, 1, 0, 1, 3, 16'hBEEF, 0, 0, 1, 0);
        check("t5_tag_err", 32'(bus.tag_err), 32'd1);
        step(1, 2, 5, 0, 0, 0, 0, 0, 2, 3);
        step(0, 0, 0, 1, 2, 16'h0777, 0, 2, 0, 1);
        check("t5_set_wins", 32'(bus.finished[1]), 32'd1);
        step(0, 0, 0, 0, 0, 0, 0, 2, 0, 1);
        check("t5_ack", 32'(bus.finished[1]), 32'd0);

`ifdef RST_FLUSH_EN
        // Flush clears tags while CDB still writes values
        step(1, 1, 1, 0, 0, 0, 0, 0, 1, 2);
        step(1, 2, 2, 0, 0, 0, 0, 0, 1, 2);
        step(0, 0, 0, 1, 1, 7, 1, 0, 1, 2);
        check("t6_flush_busy", 32'(bus.busy_count), 32'd0);
        idle(1, 2);
        check("t6_r1_val", 32'(bus.rd_val_a), 32'd7);
`endif

        // Randomized traffic, flush toggled occasionally
        for (int n = 0; n < 400; n++) begin
            step(($urandom_range(0, 3) != 0), $urandom_range(0, NUM_REGS - 1), $urandom_range(0, 3),
                 ($urandom_range(0, 2) != 0), $urandom_range(0, 3), $urandom_range(0, 16'hFFFF),
                 ($urandom_range(0, 15) == 0), $urandom_range(0, 3),
                 $urandom_range(0, NUM_REGS - 1), $urandom_range(0, NUM_REGS - 1));
        end

        // Async reset mid-cycle while a broadcast and dispatch are in flight
        step(1, 3, 2, 0, 0, 0, 0, 0, 3, 3);
        @(posedge Clock);
        bus.disp_valid = 1'b1; bus.disp_rd = 2'd1; bus.disp_tag = 3'd1;
        bus.cdb_valid = 1'b1; bus.cdb_tag = 3'd2; bus.cdb_data = 16'hDEAD;
        bus.rd_addr_a = 2'd3; bus.rd_addr_b = 2'd1;
        #2;
        Reset = 1'b1;
        #1;
        check("rst_busy", 32'(bus.busy_count), 32'd0);
        check("rst_finished", 32'(bus.finished), 32'd0);
        check("rst_tag_err", 32'(bus.tag_err), 32'd0);
        check("rst_rd_a_qi", 32'(bus.rd_qi_a), 32'd0);
        check("rst_rd_a_val", 32'(bus.rd_val_a), 32'd3);
        check("rst_rd_b_val", 32'(bus.rd_val_b), 32'd1);
        bus.disp_valid = 1'b0; bus.cdb_valid = 1'b0;
        model_reset();
        @(negedge Clock);
        @(posedge Clock);
        Reset = 1'b0;
        idle(3, 1);
        idle(0, 2);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end
endmodule
